// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path that feeds the FFT sample buffer.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 32'd10;
  localparam int unsigned SAMPLE_W_C       = 32'd16;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } byte_phase_e;

  function automatic logic [SAMPLE_W_C-1:0] pack_sample(input logic [7:0] hi_byte,
                                                        input logic [7:0] lo_byte);
    return {hi_byte, lo_byte};
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling FSM, byte/stop-error strobes.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       stop_err_o,
  output logic       busy_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, rx_s_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;

  // Next-state logic; the strobes fire in the mid-stop-bit cycle.
  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_o = 1'b0;
    stop_err_o   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        clk_cnt_d = CNT_ZERO;
        if (!rx_s_q) state_d = RX_START;
        else         state_d = RX_IDLE;
      end
      RX_START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = CNT_ZERO;
          bit_cnt_d = 3'd0;
          if (rx_s_q) state_d = RX_IDLE;
          else        state_d = RX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d          = CNT_ZERO;
          shift_d[bit_cnt_q] = rx_s_q;
          if (bit_cnt_q == 3'd7) state_d = RX_STOP;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = CNT_ZERO;
          state_d   = RX_IDLE;
          if (rx_s_q) byte_valid_o = 1'b1;
          else        stop_err_o   = 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d   = RX_IDLE;
        clk_cnt_d = CNT_ZERO;
      end
    endcase
  end

  // Synchronizer and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= RX_IDLE;
      clk_cnt_q <= CNT_ZERO;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      sync1_q   <= rx_i;
      rx_s_q    <= sync1_q;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  assign byte_o = shift_q;
  assign busy_o = (state_q != RX_IDLE);

endmodule

// File: rtl/uart_rx_sample_packer.sv
// Pairs received bytes (low then high) into signed samples, indexes them within an N-sample frame.
module uart_rx_sample_packer
  import uart_pkg::*;
#(
  parameter int unsigned N            = 32'd256,
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned SAMPLE_W     = SAMPLE_W_C
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_i,
  output logic [SAMPLE_W-1:0]  sample_o,
  output logic                 sample_valid_o,
  output logic [$clog2(N)-1:0] sample_idx_o,
  output logic                 frame_done_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [7:0] byte_s;
  logic       byte_valid_s, stop_err_s;

  byte_phase_e         phase_q, phase_d;
  logic [7:0]          low_q, low_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                sample_valid_q, sample_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                frame_err_q, frame_err_d;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_byte (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (rx_i),
    .byte_o       (byte_s),
    .byte_valid_o (byte_valid_s),
    .stop_err_o   (stop_err_s),
    .busy_o       (busy_o)
  );

  // Byte pairing; the counter wraps naturally because N is a power of two.
  always_comb begin
    phase_d        = phase_q;
    low_d          = low_q;
    cnt_d          = cnt_q;
    sample_d       = sample_q;
    idx_d          = idx_q;
    sample_valid_d = 1'b0;
    frame_done_d   = 1'b0;
    frame_err_d    = 1'b0;
    if (byte_valid_s) begin
      if (phase_q == PH_LOW) begin
        low_d   = byte_s;
        phase_d = PH_HIGH;
      end else begin
        sample_d       = SAMPLE_W'(pack_sample(byte_s, low_q));
        sample_valid_d = 1'b1;
        idx_d          = cnt_q;
        frame_done_d   = (cnt_q == LAST_IDX);
        cnt_d          = cnt_q + IDX_ONE;
        phase_d        = PH_LOW;
      end
    end else if (stop_err_s) begin
      frame_err_d = 1'b1;
      phase_d     = PH_LOW;
    end else begin
      phase_d = phase_q;
    end
  end

  // Pairing state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q        <= PH_LOW;
      low_q          <= 8'h00;
      cnt_q          <= {IDX_W{1'b0}};
      sample_q       <= {SAMPLE_W{1'b0}};
      idx_q          <= {IDX_W{1'b0}};
      sample_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      low_q          <= low_d;
      cnt_q          <= cnt_d;
      sample_q       <= sample_d;
      idx_q          <= idx_d;
      sample_valid_q <= sample_valid_d;
      frame_done_q   <= frame_done_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = sample_valid_q;
  assign sample_idx_o   = idx_q;
  assign frame_done_o   = frame_done_q;
  assign frame_err_o    = frame_err_q;

endmodule

// File: tb/tb_uart_rx_sample_packer.sv
// Directed bench: two packers (N=4) at 10 and 16 clocks per bit, driven with hand-built 8N1 frames.
module tb_uart_rx_sample_packer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a  = 1'b1;
  logic rx_b  = 1'b1;

  logic [15:0] samp_a, samp_b;
  logic [1:0]  idx_a, idx_b;
  logic        val_a, val_b, done_a, done_b, err_a, err_b, busy_a, busy_b;

  always #5 clk = ~clk;

  uart_rx_sample_packer #(.N(4), .CLKS_PER_BIT(10), .SAMPLE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_a), .sample_o(samp_a), .sample_valid_o(val_a),
    .sample_idx_o(idx_a), .frame_done_o(done_a), .frame_err_o(err_a), .busy_o(busy_a));

  uart_rx_sample_packer #(.N(4), .CLKS_PER_BIT(16), .SAMPLE_W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_b), .sample_o(samp_b), .sample_valid_o(val_b),
    .sample_idx_o(idx_b), .frame_done_o(done_b), .frame_err_o(err_b), .busy_o(busy_b));

  typedef struct {
    logic [15:0] s;
    logic [1:0]  idx;
    logic        done;
    time         t;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  int  err_cnt  = 0;
  int  busy_cnt = 0;
  int  n_checks = 0;
  int  n_fail   = 0;

  always @(negedge clk) begin
    if (val_a) qa.push_back('{samp_a, idx_a, done_a, $time});
    if (val_b) qb.push_back('{samp_b, idx_b, done_b, $time});
    if (err_a) err_cnt <= err_cnt + 1;
    if (busy_a) busy_cnt <= busy_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic ev_t get_ev(input bit sel_b, input int i);
    ev_t e;
    e.s = 16'h0; e.idx = 2'd0; e.done = 1'b0; e.t = 0;
    if (!sel_b && i < qa.size()) e = qa[i];
    if (sel_b && i < qb.size()) e = qb[i];
    return e;
  endfunction

  // Called at a negedge; drives the first nbits of {stop, data, start} LSB first.
  task automatic drive_byte(input logic [7:0] b, input logic stop_bit, input bit sel_b,
                            input int cpb, input int nbits, output time t0);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    t0 = $time;
    for (int i = 0; i < nbits; i++) begin
      if (sel_b) rx_b = frame[i];
      else       rx_a = frame[i];
      repeat (cpb) @(negedge clk);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    @(posedge clk);
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    time  t0, t_dummy;
    int   base, ebase, bbase, lat;
    ev_t  e;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_sample", 32'(samp_a), 32'h0);
    check_eq("rst_valid", 32'(val_a), 32'h0);
    check_eq("rst_idx", 32'(idx_a), 32'h0);
    check_eq("rst_done", 32'(done_a), 32'h0);
    check_eq("rst_err", 32'(err_a), 32'h0);
    check_eq("rst_busy", 32'(busy_a), 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // T1: 0x34, 0x12
    base = qa.size(); ebase = err_cnt;
    drive_byte(8'h34, 1'b1, 1'b0, 10, 10, t0);
    drive_byte(8'h12, 1'b1, 1'b0, 10, 10, t_dummy);
    settle(10);
    check_eq("t1_count", 32'(qa.size() - base), 32'd1);
    e = get_ev(1'b0, base);
    check_eq("t1_sample", 32'(e.s), 32'h1234);
    check_eq("t1_idx", 32'(e.idx), 32'd0);
    check_eq("t1_done", 32'(e.done), 32'd0);
    lat = int'((e.t - t0) / 10);
    check_eq("t1_latency_in_window", 32'(lat >= 190 && lat <= 210), 32'd1);
    check_eq("t1_no_err", 32'(err_cnt - ebase), 32'd0);

    // T2: fresh frame, 10 back-to-back 0xFF bytes
    pulse_reset();
    base = qa.size();
    for (int k = 0; k < 10; k++) drive_byte(8'hFF, 1'b1, 1'b0, 10, 10, t_dummy);
    settle(10);
    check_eq("t2_count", 32'(qa.size() - base), 32'd5);
    for (int k = 0; k < 5; k++) begin
      e = get_ev(1'b0, base + k);
      check_eq($sformatf("t2_sample%0d", k), 32'(e.s), 32'hFFFF);
      check_eq($sformatf("t2_idx%0d", k), 32'(e.idx), 32'(k % 4));
      check_eq($sformatf("t2_done%0d", k), 32'(e.done), 32'(k == 3));
    end

    // T3: 3-cycle glitch in IDLE
    @(negedge clk);
    base = qa.size(); ebase = err_cnt; bbase = busy_cnt;
    rx_a = 1'b0;
    repeat (3) @(negedge clk);
    rx_a = 1'b1;
    settle(30);
    check_eq("t3_no_sample", 32'(qa.size() - base), 32'd0);
    check_eq("t3_no_err", 32'(err_cnt - ebase), 32'd0);
    check_eq("t3_busy_1_to_5", 32'((busy_cnt - bbase) >= 1 && (busy_cnt - bbase) <= 5), 32'd1);

    // T4: stop error then a good pair; counter continues at 1
    @(negedge clk);
    base = qa.size(); ebase = err_cnt;
    drive_byte(8'h55, 1'b0, 1'b0, 10, 10, t_dummy);
    rx_a = 1'b1;
    settle(20);
    check_eq("t4_err_one_pulse", 32'(err_cnt - ebase), 32'd1);
    check_eq("t4_no_sample_on_err", 32'(qa.size() - base), 32'd0);
    @(negedge clk);
    drive_byte(8'h01, 1'b1, 1'b0, 10, 10, t_dummy);
    drive_byte(8'h80, 1'b1, 1'b0, 10, 10, t_dummy);
    settle(10);
    check_eq("t4_count", 32'(qa.size() - base), 32'd1);
    e = get_ev(1'b0, base);
    check_eq("t4_sample", 32'(e.s), 32'h8001);
    check_eq("t4_idx", 32'(e.idx), 32'd1);

    // T5: reset during DATA of the high byte
    @(negedge clk);
    base = qa.size();
    drive_byte(8'h11, 1'b1, 1'b0, 10, 10, t_dummy);
    drive_byte(8'h22, 1'b1, 1'b0, 10, 4, t_dummy);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_sample", 32'(samp_a), 32'h0);
    check_eq("t5_rst_idx", 32'(idx_a), 32'h0);
    check_eq("t5_rst_busy", 32'(busy_a), 32'h0);
    check_eq("t5_rst_valid", 32'(val_a), 32'h0);
    rx_a = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    settle(5);
    check_eq("t5_no_pulse", 32'(qa.size() - base), 32'd0);
    @(negedge clk);
    drive_byte(8'hAA, 1'b1, 1'b0, 10, 10, t_dummy);
    drive_byte(8'h00, 1'b1, 1'b0, 10, 10, t_dummy);
    settle(10);
    check_eq("t5_count", 32'(qa.size() - base), 32'd1);
    e = get_ev(1'b0, base);
    check_eq("t5_sample", 32'(e.s), 32'h00AA);
    check_eq("t5_idx", 32'(e.idx), 32'd0);

    // T6: 16 clocks per bit
    @(negedge clk);
    base = qb.size();
    drive_byte(8'h00, 1'b1, 1'b1, 16, 10, t0);
    drive_byte(8'h7F, 1'b1, 1'b1, 16, 10, t_dummy);
    settle(10);
    check_eq("t6_count", 32'(qb.size() - base), 32'd1);
    e = get_ev(1'b1, base);
    check_eq("t6_sample", 32'(e.s), 32'h7F00);
    check_eq("t6_idx", 32'(e.idx), 32'd0);
    lat = int'((e.t - t0) / 10);
    check_eq("t6_latency_in_window", 32'(lat >= 305 && lat <= 330), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
